// File: rtl/spram_be.sv
// Single-port synchronous RAM with per-byte write enables, 1- or 2-cycle read latency
// and a zero-fill engine that runs after reset and on a clear pulse.
module spram_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic                  clear,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  busy
);

    // state    | meaning
    // ST_CLEAR | zero-filling mem[cnt], one word per cycle; requests ignored
    // ST_IDLE  | serving requests; clear pulse restarts the fill
    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_IDLE  = 1'b1;

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    logic              state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              v1;
    logic [DATA_W-1:0] d1;

    // clear wins over a same-cycle request, so ready drops combinationally
    assign req_ready = (state == ST_IDLE) && !clear;
    assign busy      = (state == ST_CLEAR);
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_we;
    assign wr_acc    = accept && req_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[cnt[ADDR_W-1:0]] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < NB; i++) begin
                    if (req_be[i]) begin
                        mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // d1 only loads on a read so the output holds between responses
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) begin
                d1 <= mem[req_addr];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              v2;
            logic [DATA_W-1:0] d2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
                    end
                end
            end

            assign rsp_valid = v2;
            assign rsp_rdata = d2;
        end else begin : g_lat1
            assign rsp_valid = v1;
            assign rsp_rdata = d1;
        end
    endgenerate

endmodule

// File: tb/tb_spram_be.sv
// Bench for spram_be: drives one stimulus stream into an RD_LAT=1 and an RD_LAT=2
// instance and checks responses against hand-computed expectations.
module tb_spram_be;

    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    be;
        logic [DW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          clear = 1'b0;

    logic          ready1, ready2, rv1, rv2, busy1, busy2;
    logic [DW-1:0] rd1, rd2;

    logic          mark_rd = 1'b0;
    logic [DW-1:0] mark_exp = '0;
    logic          h1_v = 1'b0, h2_v = 1'b0;
    logic [DW-1:0] h1_d = '0, h2_d = '0, last1 = '0, last2 = '0;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[12];

    spram_be #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clear(clear), .rsp_valid(rv1), .rsp_rdata(rd1), .busy(busy1)
    );

    spram_be #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .clear(clear), .rsp_valid(rv2), .rsp_rdata(rd2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [3:0] be, input logic [DW-1:0] exp);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        mark_rd   = !we;
        mark_exp  = exp;
        tick();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        mark_rd   = 1'b0;
    endtask

    // Counts edges until both instances are ready again; optional clear pulse mid-fill.
    task automatic wait_clear(input string name, input int pulse_at);
        int n;
        n = 0;
        while (n < 40 && !(ready1 && ready2)) begin
            check({name, "_busy"}, {busy1, busy2}, 2'b11);
            clear = (n == pulse_at);
            tick();
            clear = 1'b0;
            #1;
            n++;
        end
        check({name, "_cycles"}, n, 16);
        check({name, "_busy_end"}, {busy1, busy2}, 2'b00);
    endtask

    // Expected response pipeline, driven by what the stimulus says it issued.
    always @(posedge clk) begin
        if (reset) begin
            h1_v  <= 1'b0;
            h2_v  <= 1'b0;
            last1 <= '0;
            last2 <= '0;
        end else begin
            h1_v <= mark_rd;
            h1_d <= mark_exp;
            h2_v <= h1_v;
            h2_d <= h1_d;
        end
        #1;
        check("rsp_valid_lat1", rv1, h1_v);
        check("rsp_rdata_lat1", rd1, h1_v ? h1_d : last1);
        check("rsp_valid_lat2", rv2, h2_v);
        check("rsp_rdata_lat2", rd2, h2_v ? h2_d : last2);
        if (h1_v) last1 <= h1_d;
        if (h2_v) last2 <= h2_d;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'd3,  32'hAABBCCDD, 4'hF, 32'h0};
        tbl[1]  = '{1'b1, 4'd3,  32'h11223344, 4'h5, 32'h0};
        tbl[2]  = '{1'b0, 4'd3,  32'h0,        4'h0, 32'hAA22CC44};
        tbl[3]  = '{1'b1, 4'd9,  32'hDEADBEEF, 4'h0, 32'h0};
        tbl[4]  = '{1'b0, 4'd9,  32'h0,        4'h0, 32'h0};
        tbl[5]  = '{1'b1, 4'd10, 32'h12345678, 4'h8, 32'h0};
        tbl[6]  = '{1'b0, 4'd10, 32'h0,        4'h0, 32'h12000000};
        tbl[7]  = '{1'b1, 4'd3,  32'h99887766, 4'hA, 32'h0};
        tbl[8]  = '{1'b0, 4'd3,  32'h0,        4'h0, 32'h99227744};
        tbl[9]  = '{1'b0, 4'd10, 32'h0,        4'h0, 32'h12000000};
        tbl[10] = '{1'b1, 4'd10, 32'hFFFFFFFF, 4'h1, 32'h0};
        tbl[11] = '{1'b0, 4'd10, 32'h0,        4'h0, 32'h120000FF};

        // reset state and initial fill
        tick();
        tick();
        check("rst_busy", {busy1, busy2}, 2'b11);
        check("rst_ready", {ready1, ready2}, 2'b00);
        check("rst_rsp_valid", {rv1, rv2}, 2'b00);
        check("rst_rdata", {rd1, rd2}, 64'h0);
        reset = 1'b0;
        #1;
        wait_clear("init_clear", -1);

        for (int a = 0; a < 16; a++) issue(1'b0, AW'(a), '0, 4'h0, 32'h0);
        idle();
        repeat (3) tick();

        // byte-enable table, applied back to back
        for (int i = 0; i < 12; i++) issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp);
        idle();
        repeat (3) tick();

        // full fill then 16 back-to-back reads
        for (int a = 0; a < 16; a++) issue(1'b1, AW'(a), 32'(a) * 32'h01010101, 4'hF, 32'h0);
        for (int a = 0; a < 16; a++) issue(1'b0, AW'(a), '0, 4'h0, 32'(a) * 32'h01010101);
        idle();
        repeat (3) tick();

        // read in flight when clear is taken still completes
        issue(1'b1, 4'd5, 32'h5, 4'hF, 32'h0);
        issue(1'b0, 4'd5, 32'h0, 4'h0, 32'h5);
        idle();
        clear = 1'b1;
        #1;
        check("clear_blocks_ready", {ready1, ready2}, 2'b00);
        tick();
        clear = 1'b0;
        #1;
        wait_clear("clear_inflight", -1);
        issue(1'b0, 4'd5, '0, 4'h0, 32'h0);
        idle();
        repeat (3) tick();

        // clear and write in the same cycle; clear pulse during fill is ignored
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd7;
        req_wdata = 32'hFF;
        req_be    = 4'hF;
        clear     = 1'b1;
        #1;
        check("clear_vs_write_ready", {ready1, ready2}, 2'b00);
        tick();
        idle();
        clear = 1'b0;
        #1;
        wait_clear("clear_retrigger", 4);
        issue(1'b0, 4'd7, '0, 4'h0, 32'h0);
        idle();
        repeat (3) tick();

        // reset flushes a read still in the 2-cycle pipe
        issue(1'b1, 4'd4, 32'h0BADF00D, 4'hF, 32'h0);
        issue(1'b0, 4'd4, '0, 4'h0, 32'h0BADF00D);
        idle();
        reset = 1'b1;
        tick();
        check("rst_flush_valid", {rv1, rv2}, 2'b00);
        check("rst_flush_rdata", {rd1, rd2}, 64'h0);
        reset = 1'b0;
        #1;

        // reset at cycle 8 of the fill restarts it
        repeat (8) tick();
        check("mid_clear_busy", {busy1, busy2}, 2'b11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        wait_clear("rst_mid_clear", -1);
        issue(1'b0, 4'd4, '0, 4'h0, 32'h0);
        idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
